// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline constants: multiply FSM encodings and default multiply latency.
// Also consumed by the forwarding and control units.
package hazard_detection_unit_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } hdu_state_e;

   localparam int MULT_LAT_DEFAULT = 4;

   // Stall/bubble control bundle driven by the hazard unit.
   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic id_ex_bubble;
      logic ex_mem_bubble;
   } stall_ctrl_t;

   // True when a non-zero EX destination matches either ID source register.
   function automatic logic src_match(input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2);
      return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/hazard_detection_unit_sat_counter16.sv
// 16-bit event counter with enable and synchronous active-low clear.
// Sticks at 16'hFFFF instead of wrapping.
module sat_counter16 (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        en,
   output logic [15:0] count
);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count <= 16'd0;
      end else if (en && (count != 16'hFFFF)) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard unit: load-use stall, multi-cycle multiply stall in EX,
// and saturating counters for both stall kinds.
module hazard_detection_unit
   import hazard_detection_unit_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic [4:0]  rs1_IF_ID,
   input  logic [4:0]  rs2_IF_ID,
   input  logic [4:0]  rd_ID_EX,
   input  logic        mem_2_reg_EX,
   input  logic        reg_write_EX,
   input  logic        mult_EX,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        id_ex_write,
   output logic        id_ex_bubble,
   output logic        ex_mem_bubble,
   output logic        mult_busy,
   output logic [15:0] load_use_stalls,
   output logic [15:0] mult_stalls
);

   localparam logic [2:0] LAST_CNT = 3'(MULT_LAT - 1);

   hdu_state_e  state;
   logic [2:0]  cnt;
   logic        load_use;
   logic        mul_stall;
   logic        lu_stall;
   stall_ctrl_t ctrl;

   // The release cycle (MUL, cnt==LAST_CNT) never retriggers because the
   // IDLE->MUL arc is only taken from IDLE.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (mult_EX) begin
                  state <= MUL;
                  cnt   <= 3'd1;
               end
            end
            MUL: begin
               if (cnt == LAST_CNT) begin
                  state <= IDLE;
                  cnt   <= 3'd0;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 3'd0;
            end
         endcase
      end
   end

   assign load_use  = mem_2_reg_EX && reg_write_EX &&
                      src_match(rd_ID_EX, rs1_IF_ID, rs2_IF_ID);
   assign mul_stall = ((state == IDLE) && mult_EX) ||
                      ((state == MUL) && (cnt != LAST_CNT));
   assign lu_stall  = load_use && !mul_stall;

   // Multiply freezes IF/ID/EX and bubbles EX/MEM; it outranks load-use.
   always_comb begin
      ctrl = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
               id_ex_bubble: 1'b0, ex_mem_bubble: 1'b0};
      if (mul_stall) begin
         ctrl = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                  id_ex_bubble: 1'b0, ex_mem_bubble: 1'b1};
      end else if (load_use) begin
         ctrl = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                  id_ex_bubble: 1'b1, ex_mem_bubble: 1'b0};
      end
   end

   assign pc_write      = ctrl.pc_write;
   assign if_id_write   = ctrl.if_id_write;
   assign id_ex_write   = ctrl.id_ex_write;
   assign id_ex_bubble  = ctrl.id_ex_bubble;
   assign ex_mem_bubble = ctrl.ex_mem_bubble;
   assign mult_busy     = mul_stall;

   sat_counter16 u_load_use_cnt (
      .clk   (clk),
      .clr_n (arst_n),
      .en    (lu_stall),
      .count (load_use_stalls)
   );

   sat_counter16 u_mult_cnt (
      .clk   (clk),
      .clr_n (arst_n),
      .en    (mul_stall),
      .count (mult_stalls)
   );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit: driver pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares.
module tb_hazard_detection_unit;

   localparam logic [5:0] NORM = 6'b111000;
   localparam logic [5:0] LU   = 6'b001100;
   localparam logic [5:0] MS   = 6'b000011;

   logic        clk;
   logic        arst_n;
   logic [4:0]  rs1_IF_ID;
   logic [4:0]  rs2_IF_ID;
   logic [4:0]  rd_ID_EX;
   logic        mem_2_reg_EX;
   logic        reg_write_EX;
   logic        mult_EX;
   logic        pc_write;
   logic        if_id_write;
   logic        id_ex_write;
   logic        id_ex_bubble;
   logic        ex_mem_bubble;
   logic        mult_busy;
   logic [15:0] load_use_stalls;
   logic [15:0] mult_stalls;

   logic [37:0] exp_q[$];
   int          errors;
   int          checks;

   hazard_detection_unit dut (
      .clk             (clk),
      .arst_n          (arst_n),
      .rs1_IF_ID       (rs1_IF_ID),
      .rs2_IF_ID       (rs2_IF_ID),
      .rd_ID_EX        (rd_ID_EX),
      .mem_2_reg_EX    (mem_2_reg_EX),
      .reg_write_EX    (reg_write_EX),
      .mult_EX         (mult_EX),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .id_ex_write     (id_ex_write),
      .id_ex_bubble    (id_ex_bubble),
      .ex_mem_bubble   (ex_mem_bubble),
      .mult_busy       (mult_busy),
      .load_use_stalls (load_use_stalls),
      .mult_stalls     (mult_stalls)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   // driver: apply one cycle of inputs just after the edge; optionally
   // queue the expected {ctrl, load_use_stalls, mult_stalls} for that cycle
   task automatic step(input logic rst_n, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic m2r, input logic rw,
                       input logic mul, input logic chk, input logic [5:0] e_ctrl,
                       input logic [15:0] e_lu, input logic [15:0] e_ms);
      @(posedge clk);
      #1;
      arst_n       = rst_n;
      rs1_IF_ID    = rs1;
      rs2_IF_ID    = rs2;
      rd_ID_EX     = rd;
      mem_2_reg_EX = m2r;
      reg_write_EX = rw;
      mult_EX      = mul;
      if (chk) exp_q.push_back({e_ctrl, e_lu, e_ms});
   endtask

   task automatic idle(input logic [5:0] e_ctrl, input logic [15:0] e_lu,
                       input logic [15:0] e_ms);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, e_ctrl, e_lu, e_ms);
   endtask

   // scoreboard monitor
   initial begin
      logic [37:0] exp_v;
      logic [5:0]  act_ctrl;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_v    = exp_q.pop_front();
            act_ctrl = {pc_write, if_id_write, id_ex_write, id_ex_bubble,
                        ex_mem_bubble, mult_busy};
            checks++;
            if (act_ctrl !== exp_v[37:32]) begin
               errors++;
               $display("FAIL ctrl @%0t: got %b want %b", $time, act_ctrl, exp_v[37:32]);
            end
            checks++;
            if ({load_use_stalls, mult_stalls} !== exp_v[31:0]) begin
               errors++;
               $display("FAIL counters @%0t: got lu=%0d ms=%0d want lu=%0d ms=%0d",
                        $time, load_use_stalls, mult_stalls, exp_v[31:16], exp_v[15:0]);
            end
         end
      end
   end

   initial begin
      errors = 0;
      checks = 0;
      arst_n = 1'b0; rs1_IF_ID = '0; rs2_IF_ID = '0; rd_ID_EX = '0;
      mem_2_reg_EX = 1'b0; reg_write_EX = 1'b0; mult_EX = 1'b0;
      repeat (2) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 16'd0, 16'd0);
      // reset values with idle inputs
      idle(NORM, 16'd0, 16'd0);
      // load x5 in EX, rs2 == 5
      step(1'b1, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, LU, 16'd0, 16'd0);
      idle(NORM, 16'd1, 16'd0);
      // rd == 0 never stalls
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, NORM, 16'd1, 16'd0);
      // match but not writing, then writing but not a load
      step(1'b1, 5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, NORM, 16'd1, 16'd0);
      step(1'b1, 5'd3, 5'd9, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, NORM, 16'd1, 16'd0);
      // rs1 match
      step(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, LU, 16'd1, 16'd0);
      idle(NORM, 16'd2, 16'd0);
      // multiply held 4 cycles: 3 stalls, release on 4th
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MS, 16'd2, 16'd0);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MS, 16'd2, 16'd1);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MS, 16'd2, 16'd2);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORM, 16'd2, 16'd3);
      idle(NORM, 16'd2, 16'd3);
      // back-to-back: mult_EX held 8 cycles -> two separate 3-cycle stalls
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MS, 16'd2, 16'd3);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MS, 16'd2, 16'd4);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MS, 16'd2, 16'd5);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORM, 16'd2, 16'd6);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MS, 16'd2, 16'd6);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MS, 16'd2, 16'd7);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MS, 16'd2, 16'd8);
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORM, 16'd2, 16'd9);
      idle(NORM, 16'd2, 16'd9);
      // multiply together with load-use: multiply wins, load-use surfaces on release
      step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, MS, 16'd2, 16'd9);
      step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, MS, 16'd2, 16'd10);
      step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, MS, 16'd2, 16'd11);
      step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, LU, 16'd2, 16'd12);
      idle(NORM, 16'd3, 16'd12);
      // reset on cycle 2 of a multiply aborts it and clears counters
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, MS, 16'd3, 16'd12);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, MS, 16'd3, 16'd13);
      idle(NORM, 16'd0, 16'd0);
      idle(NORM, 16'd0, 16'd0);
      // 65540 consecutive load-use cycles: counter saturates at 16'hFFFF
      for (int k = 0; k < 65540; k++) begin
         step(1'b1, 5'd2, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, LU,
              (k > 65535) ? 16'hFFFF : 16'(k), 16'd0);
      end
      idle(NORM, 16'hFFFF, 16'd0);
      idle(NORM, 16'hFFFF, 16'd0);
      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
